game_state_ctrl: RTL and testbench
==================================

Name: game_state_ctrl

Overview:
- Downstream consumer of the bird coordinate generator.
- Each frame it checks the bird box against the current pipe, the floor and the ceiling, and keeps the score and high score.
- Runs the game state machine (IDLE/PLAY/HIT/OVER).
- Issues the one-cycle reset_game pulse that re-arms the bird generator and the pipe generator.

Parameters:
- BIRD_W, 34, bird sprite width in pixels
- BIRD_H, 24, bird sprite height in pixels
- PIPE_W, 80, pipe width in pixels
- GAP_H, 200, vertical opening of the pipe gap in pixels
- FLOOR_Y, 680, y of the ground line
- HIT_FRAMES, 30, move ticks spent in HIT before OVER
- SCORE_MAX, 999, score saturation value

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- move  in  1  frame tick, one clk wide, one per frame
- start  in  1  one-clk pulse from the debounced flap key
- bird_x  in  11  bird left edge
- bird_y  in  11  bird top edge; values >= 1024 mean the bird wrapped above the screen
- pipe_x  in  11  current pipe left edge; wraps back to the right side after exiting on the left
- gap_y  in  11  top edge of the current pipe gap
- reset_game  out  1  one-clk pulse on entry to PLAY
- playing  out  1  high in PLAY
- game_over  out  1  high in HIT and OVER
- score  out  10  pipes passed in the current game
- high_score  out  10  best score since reset_n

Behaviour:
- Clock and reset: single clock domain. reset_n low asynchronously forces state=IDLE and clears all registers; every output reads 0.
- Arithmetic: all compares are 12-bit unsigned, with inputs zero-extended.
- hit_pipe = (bird_x+BIRD_W > pipe_x) and (bird_x < pipe_x+PIPE_W) and ((bird_y < gap_y) or (bird_y+BIRD_H > gap_y+GAP_H)).
- hit_floor = bird_y+BIRD_H >= FLOOR_Y.
- hit_ceil = bird_y[10].
- collide = hit_pipe or hit_floor or hit_ceil. It is sampled only in a cycle where move=1 and state=PLAY.
- Pass detection:
  - passed flag is set on a PLAY move tick when pipe_x+PIPE_W < bird_x and passed=0; score increments by 1 on that tick, saturating at SCORE_MAX.
  - passed is cleared on any move tick with pipe_x > bird_x (pipe wrapped).
  - passed is cleared on reset_game.
- Simultaneous collide and pass on one tick: collide wins, score is unchanged.
- FSM:
  - IDLE: start=1 -> PLAY. In the same edge, reset_game=1 for one cycle, score=0, passed=0.
  - PLAY: a move tick with collide=1 -> HIT. At that edge, hit_cnt=0 and high_score=max(high_score,score). start is ignored in PLAY.
  - HIT: hit_cnt increments on each move tick. A tick with hit_cnt==HIT_FRAMES-1 -> OVER. start is ignored in HIT.
  - OVER: start=1 -> PLAY, with a reset_game pulse and score cleared. score holds its final value until then.
- Latency:
  - All outputs are registered.
  - reset_game, playing and game_over change one clk after the qualifying input cycle.
  - reset_game is never high two consecutive cycles.
- move and start together in IDLE/OVER: the start transition is taken; that move tick performs no collision or score evaluation.
- reset_n asserted mid-game: immediate IDLE, and high_score is lost.
- The block has no dependency on move frequency. Non-move cycles only accept start and hold state.

Test Plan:
- Power-up:
  - Stimulus: reset_n low, then release; pulse start.
  - Required: all outputs 0 while reset is low; after start, reset_game=1 for exactly one clk and playing=1 the next clk.
- Clean pass:
  - Stimulus: PLAY, bird_x=125, bird_y=360, gap_y=300. Sweep pipe_x from 300 down to 0 in steps of 4 per move tick, then wrap to 640 and sweep again.
  - Required: score becomes 1 on the tick where pipe_x+80 < 125 (pipe_x=44), and stays 1 until the wrap; after the second sweep score=2.
- Pipe hit:
  - Stimulus: PLAY, bird_x=125, pipe_x=100, gap_y=400, bird_y=360; one move tick.
  - Required: game_over=1, playing=0 next clk; high_score captures score.
- Floor and ceiling:
  - Stimulus A: bird_y=656 (656+24=680) on a move tick. Required: HIT.
  - Stimulus B: bird_y=1990 (wrapped) on a move tick. Required: HIT.
  - Stimulus C: bird_y=655 with no pipe overlap. Required: stays PLAY.
- HIT timing and restart:
  - Stimulus: after entering HIT, apply 29 move ticks, then a 30th; pulse start during HIT; then pulse start in OVER.
  - Required: state still HIT after 29 ticks, OVER after the 30th; start during HIT is ignored; start in OVER gives a reset_game pulse, score=0, high_score retained.
- Corner cases:
  - Stimulus: same-tick collide with pass condition; score preset to 999 with a further pass; reset_n pulsed during PLAY.
  - Required: collide wins with score unchanged; score stays 999; reset_n during PLAY gives immediate IDLE with all outputs 0.

Source files
------------

// File: rtl/game_state_ctrl.sv
// Game state controller: collision checks against pipe/floor/ceiling, score and high
// score tracking, and the IDLE/PLAY/HIT/OVER state machine with its reset_game pulse.
module game_state_ctrl #(
  parameter int BIRD_W     = 34,
  parameter int BIRD_H     = 24,
  parameter int PIPE_W     = 80,
  parameter int GAP_H      = 200,
  parameter int FLOOR_Y    = 680,
  parameter int HIT_FRAMES = 30,
  parameter int SCORE_MAX  = 999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        move,
  input  logic        start,
  input  logic [10:0] bird_x,
  input  logic [10:0] bird_y,
  input  logic [10:0] pipe_x,
  input  logic [10:0] gap_y,
  output logic        reset_game,
  output logic        playing,
  output logic        game_over,
  output logic [9:0]  score,
  output logic [9:0]  high_score
);

  localparam int               CNT_W     = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HIT_FRAMES - 1);
  localparam logic [9:0]       SCORE_SAT = 10'(SCORE_MAX);
  localparam logic [11:0]      BIRD_W12  = 12'(BIRD_W);
  localparam logic [11:0]      BIRD_H12  = 12'(BIRD_H);
  localparam logic [11:0]      PIPE_W12  = 12'(PIPE_W);
  localparam logic [11:0]      GAP_H12   = 12'(GAP_H);
  localparam logic [11:0]      FLOOR_Y12 = 12'(FLOOR_Y);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HIT  = 2'd2,
    S_OVER = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             passed_q, passed_d;
  logic [9:0]       score_q, score_d;
  logic [9:0]       high_q, high_d;
  logic             reset_game_q, reset_game_d;
  logic             playing_q, playing_d;
  logic             game_over_q, game_over_d;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v >= SCORE_SAT) ? SCORE_SAT : v + 10'd1;
  endfunction

  function automatic logic [9:0] max10(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [11:0] bx, by, px, gy;
  logic        hit_pipe, hit_floor, hit_ceil, collide;
  logic        pass_cond, wrap_cond;
  logic        start_game, play_tick, hit_tick;

  assign bx = {1'b0, bird_x};
  assign by = {1'b0, bird_y};
  assign px = {1'b0, pipe_x};
  assign gy = {1'b0, gap_y};

  assign hit_pipe  = (bx + BIRD_W12 > px) && (bx < px + PIPE_W12) &&
                     ((by < gy) || (by + BIRD_H12 > gy + GAP_H12));
  assign hit_floor = (by + BIRD_H12 >= FLOOR_Y12);
  // bird_y at or above 1024 is a bird that flew off the top and wrapped
  assign hit_ceil  = bird_y[10];
  assign collide   = hit_pipe || hit_floor || hit_ceil;
  assign pass_cond = (px + PIPE_W12 < bx);
  assign wrap_cond = (px > bx);

  assign start_game = start && ((state_q == S_IDLE) || (state_q == S_OVER));
  assign play_tick  = move && (state_q == S_PLAY);
  assign hit_tick   = move && (state_q == S_HIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_PLAY;
      S_PLAY:  if (move && collide) state_d = S_HIT;
      S_HIT:   if (move && (hit_cnt_q == CNT_LAST)) state_d = S_OVER;
      S_OVER:  if (start) state_d = S_PLAY;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    reset_game_d = start_game;
    playing_d    = (state_d == S_PLAY);
    game_over_d  = (state_d == S_HIT) || (state_d == S_OVER);
  end

  // A start in IDLE/OVER pre-empts any evaluation on the same move tick.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    passed_d  = passed_q;
    score_d   = score_q;
    high_d    = high_q;
    if (start_game) begin
      passed_d = 1'b0;
      score_d  = 10'd0;
    end else begin
      if (move && wrap_cond) passed_d = 1'b0;
      if (play_tick) begin
        if (collide) begin
          hit_cnt_d = '0;
          high_d    = max10(high_q, score_q);
        end else if (pass_cond && !passed_q) begin
          passed_d = 1'b1;
          score_d  = sat_inc(score_q);
        end
      end
      if (hit_tick && (hit_cnt_q != CNT_LAST)) hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q    <= '0;
      passed_q     <= 1'b0;
      score_q      <= 10'd0;
      high_q       <= 10'd0;
      reset_game_q <= 1'b0;
      playing_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      hit_cnt_q    <= hit_cnt_d;
      passed_q     <= passed_d;
      score_q      <= score_d;
      high_q       <= high_d;
      reset_game_q <= reset_game_d;
      playing_q    <= playing_d;
      game_over_q  <= game_over_d;
    end
  end

  assign reset_game = reset_game_q;
  assign playing    = playing_q;
  assign game_over  = game_over_q;
  assign score      = score_q;
  assign high_score = high_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: constant vector table, directed corner sequences, and a
// randomized run checked against a rule-level game model.
module tb_game_state_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        move = 1'b0;
  logic        start = 1'b0;
  logic [10:0] bird_x = '0, bird_y = '0, pipe_x = '0, gap_y = '0;
  logic        reset_game, playing, game_over;
  logic [9:0]  score, high_score;

  game_state_ctrl dut (
    .clk(clk), .reset_n(reset_n), .move(move), .start(start),
    .bird_x(bird_x), .bird_y(bird_y), .pipe_x(pipe_x), .gap_y(gap_y),
    .reset_game(reset_game), .playing(playing), .game_over(game_over),
    .score(score), .high_score(high_score)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Game model: which phase we are in, frames left in the crash animation, scores.
  bit m_play, m_hit, m_over, m_passed, m_rg;
  int m_left, m_score, m_high;

  function automatic void m_reset();
    m_play = 0; m_hit = 0; m_over = 0; m_passed = 0; m_rg = 0;
    m_left = 0; m_score = 0; m_high = 0;
  endfunction

  function automatic void m_step();
    int bx, by, px, gy;
    bit crash;
    bx = bird_x; by = bird_y; px = pipe_x; gy = gap_y;
    m_rg = 0;
    if (!m_play && !m_hit && start) begin
      m_play = 1; m_over = 0; m_score = 0; m_passed = 0; m_rg = 1;
    end else if (move) begin
      if (px > bx) m_passed = 0;
      if (m_play) begin
        crash = (bx + 34 > px && bx < px + 80 && (by < gy || by + 24 > gy + 200))
                || (by + 24 >= 680) || (by >= 1024);
        if (crash) begin
          m_play = 0; m_hit = 1; m_left = 30;
          if (m_score > m_high) m_high = m_score;
        end else if (px + 80 < bx && !m_passed) begin
          m_passed = 1;
          if (m_score < 999) m_score = m_score + 1;
        end
      end else if (m_hit) begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_hit = 0; m_over = 1; end
      end
    end
  endfunction

  task automatic cmp_model(input string tag);
    chk({tag, " reset_game"}, int'(reset_game), int'(m_rg));
    chk({tag, " playing"},    int'(playing),    int'(m_play));
    chk({tag, " game_over"},  int'(game_over),  int'(m_hit | m_over));
    chk({tag, " score"},      int'(score),      m_score);
    chk({tag, " high_score"}, int'(high_score), m_high);
  endtask

  task automatic tick(input bit mv, input bit st, input string tag);
    move = mv; start = st;
    @(posedge clk);
    m_step();
    #1;
    cmp_model(tag);
    move = 0; start = 0;
  endtask

  task automatic set_in(input int bx, input int by, input int px, input int gy);
    bird_x = 11'(bx); bird_y = 11'(by); pipe_x = 11'(px); gap_y = 11'(gy);
  endtask

  task automatic finish_hit_and_restart();
    set_in(125, 360, 640, 300);
    repeat (30) tick(1, 0, "hit_run");
    tick(0, 1, "restart");
  endtask

  typedef struct {
    bit mv; bit st; int by; int px;
    bit rg; bit pl; bit go; int sc; int hi;
  } vec_t;

  vec_t vt[9];

  initial begin
    vt[0] = '{0, 1, 360, 300, 1, 1, 0, 0, 0};
    vt[1] = '{0, 0, 360, 300, 0, 1, 0, 0, 0};
    vt[2] = '{1, 0, 360,   0, 0, 1, 0, 1, 0};
    vt[3] = '{1, 0, 360, 640, 0, 1, 0, 1, 0};
    vt[4] = '{1, 0, 360,   0, 0, 1, 0, 2, 0};
    vt[5] = '{1, 0, 360,  10, 0, 1, 0, 2, 0};
    vt[6] = '{1, 1, 655,   0, 0, 1, 0, 2, 0};
    vt[7] = '{1, 0, 656,   0, 0, 0, 1, 2, 2};
    vt[8] = '{0, 1, 360,   0, 0, 0, 1, 2, 2};

    m_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst reset_game", int'(reset_game), 0);
    chk("rst playing",    int'(playing),    0);
    chk("rst game_over",  int'(game_over),  0);
    chk("rst score",      int'(score),      0);
    chk("rst high_score", int'(high_score), 0);
    reset_n = 1'b1;
    tick(0, 0, "idle");

    for (int i = 0; i < 9; i++) begin
      set_in(125, vt[i].by, vt[i].px, 300);
      move = vt[i].mv; start = vt[i].st;
      @(posedge clk);
      m_step();
      #1;
      chk($sformatf("vec%0d reset_game", i), int'(reset_game), int'(vt[i].rg));
      chk($sformatf("vec%0d playing", i),    int'(playing),    int'(vt[i].pl));
      chk($sformatf("vec%0d game_over", i),  int'(game_over),  int'(vt[i].go));
      chk($sformatf("vec%0d score", i),      int'(score),      vt[i].sc);
      chk($sformatf("vec%0d high", i),       int'(high_score), vt[i].hi);
      move = 0; start = 0;
    end

    // Crash animation: 29 more ticks then start must be ignored; 30th ends in OVER.
    set_in(125, 360, 640, 300);
    repeat (29) tick(1, 0, "hit29");
    tick(0, 1, "start_in_hit");
    chk("start in HIT ignored", int'(reset_game), 0);
    chk("still game_over", int'(game_over), 1);
    tick(1, 0, "hit30");
    tick(0, 1, "start_in_over");
    chk("over restart pulse", int'(reset_game), 1);
    chk("over restart score", int'(score), 0);
    chk("over restart high", int'(high_score), 2);
    tick(0, 0, "post_restart");
    chk("pulse one cycle", int'(reset_game), 0);
    chk("playing after restart", int'(playing), 1);

    // Clean pass sweep, two laps.
    set_in(125, 360, 300, 300);
    for (int p = 300; p >= 0; p -= 4) begin
      pipe_x = 11'(p);
      tick(1, 0, "sweep1");
      if (p == 48) chk("sweep1 before pass", int'(score), 0);
      if (p == 44) chk("sweep1 at pass", int'(score), 1);
    end
    chk("sweep1 end", int'(score), 1);
    for (int p = 640; p >= 0; p -= 4) begin
      pipe_x = 11'(p);
      tick(1, 0, "sweep2");
    end
    chk("sweep2 end", int'(score), 2);
    pipe_x = 11'd640; tick(1, 0, "wrap3");
    pipe_x = 11'd0;   tick(1, 0, "pass3");
    chk("third pass", int'(score), 3);

    // Pipe hit with bird above the gap.
    set_in(125, 360, 100, 400);
    tick(1, 0, "pipe_hit");
    chk("pipe hit game_over", int'(game_over), 1);
    chk("pipe hit playing", int'(playing), 0);
    chk("pipe hit high", int'(high_score), 3);

    // Wrapped-above-screen bird.
    finish_hit_and_restart();
    set_in(125, 1990, 640, 300);
    tick(1, 0, "ceiling");
    chk("ceiling hit", int'(game_over), 1);

    // Collide and pass on the same tick.
    finish_hit_and_restart();
    set_in(125, 360, 0, 300);   tick(1, 0, "cp_pass");
    set_in(125, 360, 640, 300); tick(1, 0, "cp_wrap");
    set_in(125, 656, 0, 300);   tick(1, 0, "cp_both");
    chk("collide wins score", int'(score), 1);
    chk("collide wins state", int'(game_over), 1);

    // Score saturation.
    finish_hit_and_restart();
    set_in(125, 360, 0, 300);
    for (int k = 0; k < 999; k++) begin
      pipe_x = 11'd0;   tick(1, 0, "sat_pass");
      pipe_x = 11'd640; tick(1, 0, "sat_wrap");
    end
    chk("score reaches max", int'(score), 999);
    pipe_x = 11'd0; tick(1, 0, "sat_extra");
    chk("score saturates", int'(score), 999);

    // Asynchronous reset mid-game.
    #2 reset_n = 1'b0;
    #1;
    chk("async rst playing", int'(playing), 0);
    chk("async rst score", int'(score), 0);
    chk("async rst high", int'(high_score), 0);
    chk("async rst game_over", int'(game_over), 0);
    m_reset();
    #3 reset_n = 1'b1;
    tick(0, 0, "after_rst");

    // Randomized play.
    for (int r = 0; r < 4000; r++) begin
      bird_x = 11'($urandom_range(60, 200));
      if ($urandom_range(0, 15) == 0) bird_y = 11'($urandom_range(1024, 2047));
      else bird_y = 11'($urandom_range(150, 700));
      pipe_x = 11'($urandom_range(0, 700));
      gap_y  = 11'($urandom_range(100, 480));
      tick(($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
